// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding and line constants
// for the usb_tx_bitpipe transmit pipeline.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    ABORT,
    EOP
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [1:0] LINE_J    = 2'b10;
  localparam logic [1:0] LINE_K    = 2'b01;
  localparam logic [1:0] LINE_SE0  = 2'b00;

endpackage

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: synchronous byte+flag FIFO with
// occupancy count and a single-cycle flush.
module usb_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_L,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_L || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/usb_tx_bitpipe.sv
// usb_tx_bitpipe: FIFO-buffered USB transmit line pipeline
// (SYNC, bit stuffing, NRZI, EOP, abort, underrun).
module usb_tx_bitpipe
  import usb_tx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int START_THRESH = 4,
  parameter int BIT_DIV      = 1,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       abort,
  output logic       dp,
  output logic       dm,
  output logic       oe,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BW = $clog2(EOP_SE0_BITS + 9);
  localparam int SW = $clog2(STUFF_LEN + 2);

  state_t        state, state_n;
  logic [DW-1:0] div;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [7:0]    sh, sh_n;
  logic          last_q, last_n;
  logic [SW-1:0] scnt, scnt_n, ones;
  logic          lvl, lvl_n;
  logic          abort_q, flush_q, urun_q;
  logic [CW-1:0] nlast, count;
  logic [8:0]    rdata;
  logic          full, empty;
  logic          strobe, active, go_abort, start;
  logic          acc, push, pop, fifo_flush;
  logic          urun_set, ab_flush;
  logic          cur_bit, nbit, emit, adv, load, to_eop;

  usb_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(9)
  ) u_fifo (
    .clk  (clk),
    .rst_L(rst_L),
    .flush(fifo_flush),
    .push (push),
    .wdata({in_last, in_data}),
    .pop  (pop),
    .rdata(rdata),
    .full (full),
    .empty(empty),
    .count(count)
  );

  assign strobe     = div == DW'(BIT_DIV - 1);
  assign active     = state inside {SYNC, DATA, STUFF};
  assign go_abort   = active & (abort | abort_q);
  assign start      = (nlast != '0) || (count >= CW'(START_THRESH));
  assign in_ready   = rst_L & (flush_q | (~full & (state != ABORT)));
  assign acc        = in_valid & in_ready;
  assign push       = acc & ~flush_q;
  assign fifo_flush = ab_flush | ((state == IDLE) & abort);
  assign busy       = state != IDLE;
  assign underrun   = urun_q;
  assign ones       = cur_bit ? scnt + 1'b1 : '0;

  always_comb begin
    unique case (state)
      SYNC:    cur_bit = SYNC_BYTE[bcnt[2:0]];
      DATA:    cur_bit = sh[0];
      default: cur_bit = 1'b0;
    endcase
  end

  always_comb begin
    oe       = 1'b1;
    {dp, dm} = lvl ? LINE_J : LINE_K;
    unique case (state)
      IDLE: begin
        oe       = 1'b0;
        {dp, dm} = LINE_J;
      end
      EOP: begin
        {dp, dm} = (bcnt < BW'(EOP_SE0_BITS)) ? LINE_SE0 : LINE_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    sh_n     = sh;
    last_n   = last_q;
    scnt_n   = scnt;
    lvl_n    = lvl;
    pop      = 1'b0;
    urun_set = 1'b0;
    ab_flush = 1'b0;
    nbit     = 1'b1;
    emit     = 1'b0;
    adv      = 1'b0;
    load     = 1'b0;
    to_eop   = 1'b0;
    if (strobe) begin
      scnt_n = ones;
      unique case (state)
        IDLE: begin
          if (!abort && start) begin
            state_n = SYNC;
            bcnt_n  = '0;
            nbit    = SYNC_BYTE[0];
            emit    = 1'b1;
          end
        end
        SYNC: begin
          if (bcnt == BW'(7)) begin
            load = 1'b1;
          end else begin
            bcnt_n = bcnt + 1'b1;
            nbit   = SYNC_BYTE[bcnt[2:0] + 3'd1];
            emit   = 1'b1;
          end
        end
        DATA: begin
          if (ones == SW'(STUFF_LEN)) begin
            state_n = STUFF;
            scnt_n  = '0;
            nbit    = 1'b0;
            emit    = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
        STUFF: adv = 1'b1;
        ABORT: begin
          if (bcnt == BW'(7)) to_eop = 1'b1;
          else bcnt_n = bcnt + 1'b1;
        end
        EOP: begin
          if (bcnt == BW'(EOP_SE0_BITS)) state_n = IDLE;
          else bcnt_n = bcnt + 1'b1;
        end
        default: state_n = IDLE;
      endcase
      // byte boundary: finish packet, detect underrun or fetch next byte
      if (adv) begin
        if (bcnt != BW'(7)) begin
          state_n = DATA;
          bcnt_n  = bcnt + 1'b1;
          sh_n    = sh >> 1;
          nbit    = sh[1];
          emit    = 1'b1;
        end else if (last_q) begin
          to_eop = 1'b1;
        end else if (empty) begin
          to_eop   = 1'b1;
          urun_set = 1'b1;
        end else begin
          load = 1'b1;
        end
      end
      if (load) begin
        pop     = 1'b1;
        state_n = DATA;
        bcnt_n  = '0;
        sh_n    = rdata[7:0];
        last_n  = rdata[8];
        nbit    = rdata[0];
        emit    = 1'b1;
      end
      if (to_eop) begin
        state_n = EOP;
        bcnt_n  = '0;
        lvl_n   = 1'b1;
      end
      if (emit) lvl_n = nbit ? lvl : ~lvl;
      if (go_abort) begin
        state_n  = ABORT;
        bcnt_n   = '0;
        scnt_n   = '0;
        lvl_n    = lvl;
        pop      = 1'b0;
        urun_set = 1'b0;
        ab_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state   <= IDLE;
      div     <= '0;
      bcnt    <= '0;
      sh      <= '0;
      last_q  <= 1'b0;
      scnt    <= '0;
      lvl     <= 1'b1;
      abort_q <= 1'b0;
      flush_q <= 1'b0;
      urun_q  <= 1'b0;
      nlast   <= '0;
    end else begin
      state   <= state_n;
      div     <= strobe ? '0 : div + 1'b1;
      bcnt    <= bcnt_n;
      sh      <= sh_n;
      last_q  <= last_n;
      scnt    <= scnt_n;
      lvl     <= lvl_n;
      abort_q <= go_abort & ~strobe;
      urun_q  <= urun_set;
      if (urun_set) flush_q <= 1'b1;
      else if (acc & in_last & flush_q) flush_q <= 1'b0;
      if (fifo_flush) nlast <= '0;
      else nlast <= nlast + CW'(push & in_last) - CW'(pop & rdata[8]);
    end
  end

endmodule

// File: tb/tb_usb_tx_bitpipe.sv
// tb_usb_tx_bitpipe: random and directed packets checked
// cycle-by-cycle against a behavioural line model.
module tb_usb_tx_bitpipe;

  typedef logic [1:0] sym_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_L;
  logic [1:0][7:0] in_data;
  logic [1:0]      in_valid, in_last, abort_s;
  logic [1:0]      rdy, dp, dm, oe, busy, urun;
  logic [1:0]      chk_en;

  int tests = 0;
  int fails = 0;
  int oe_cyc[2];
  int urun_cnt[2];
  logic [1:0] exp_q[2][$];

  usb_tx_bitpipe dut0 (
    .clk(clk), .rst_L(rst_L),
    .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(rdy[0]),
    .abort(abort_s[0]), .dp(dp[0]), .dm(dm[0]),
    .oe(oe[0]), .busy(busy[0]), .underrun(urun[0])
  );

  usb_tx_bitpipe #(.BIT_DIV(4)) dut1 (
    .clk(clk), .rst_L(rst_L),
    .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(rdy[1]),
    .abort(abort_s[1]), .dp(dp[1]), .dm(dm[1]),
    .oe(oe[1]), .busy(busy[1]), .underrun(urun[1])
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  // Line model: SYNC + data bits LSB-first, stuff a 0 after
  // STUFF_LEN ones, NRZI (0 toggles), then SE0,SE0,J.
  function automatic sym_q_t model(input byte_q_t bytes);
    sym_q_t s;
    logic [7:0] sync = 8'h80;
    logic [7:0] b;
    logic bv;
    logic lv = 1'b1;
    int ones = 0;
    for (int i = 0; i < 8 + 8 * bytes.size(); i++) begin
      if (i < 8) bv = sync[i];
      else begin
        b = bytes[(i - 8) / 8];
        bv = b[(i - 8) % 8];
      end
      if (!bv) lv = !lv;
      s.push_back(lv ? J : K);
      ones = bv ? ones + 1 : 0;
      if (ones == 6) begin
        lv = !lv;
        s.push_back(lv ? J : K);
        ones = 0;
      end
    end
    s.push_back(SE0);
    s.push_back(SE0);
    s.push_back(J);
    return s;
  endfunction

  task automatic load_exp(input int d, input sym_q_t s, input int dv);
    foreach (s[i]) repeat (dv) exp_q[d].push_back(s[i]);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk_en[d]) begin
        if (oe[d]) begin
          oe_cyc[d]++;
          if (exp_q[d].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL line_extra dut%0d: got %b, required oe=0",
                     d, {dp[d], dm[d]});
          end else begin
            chk($sformatf("line_dut%0d", d), {dp[d], dm[d]},
                exp_q[d].pop_front());
          end
        end else begin
          chk($sformatf("idle_j_dut%0d", d), {dp[d], dm[d]}, J);
        end
        if (urun[d]) begin
          urun_cnt[d]++;
          chk("urun_se0", {dp[d], dm[d]}, SE0);
        end
      end
    end
  end

  task automatic push(input int d, input logic [7:0] b, input logic l);
    bit ok = 0;
    int n = 0;
    in_data[d] = b;
    in_last[d] = l;
    in_valid[d] = 1'b1;
    while (!ok && n < 3000) begin
      ok = rdy[d];
      @(negedge clk);
      n++;
    end
    in_valid[d] = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push_timeout dut%0d: byte %h not taken, required ready", d, b);
    end
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!busy[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    while (busy[d] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_end", busy[d], 0);
    repeat (3) @(negedge clk);
    chk("drain", exp_q[d].size(), 0);
  endtask

  task automatic idle_hold(input int d, input string nm);
    int b = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy[d]) b++;
    end
    chk(nm, b, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sym_q_t s, full;
    byte_q_t bytes;
    int n, len, d;
    rst_L = 1'b0;
    in_data = '0;
    in_valid = '0;
    in_last = '0;
    abort_s = '0;
    chk_en = '0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_dp", dp[i], 1);
      chk("rst_dm", dm[i], 0);
      chk("rst_oe", oe[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_urun", urun[i], 0);
      chk("rst_rdy", rdy[i], 0);
    end
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", rdy, 2'b11);
    chk_en = 2'b11;

    bytes = {8'hFF};
    s = model(bytes);
    chk("model_ff_len", s.size(), 20);
    chk("model_ff_pre", s[12], K);
    chk("model_ff_stuff", s[13], J);
    load_exp(0, s, 1);
    oe_cyc[0] = 0;
    push(0, 8'hFF, 1);
    wait_done(0);
    chk("ff_oe_cycles", oe_cyc[0], 20);

    bytes = {8'h00, 8'hA5};
    s = model(bytes);
    chk("model_a5_len", s.size(), 27);
    chk("model_sync_end", s[7], K);
    chk("model_a5_end", s[23], K);
    chk("model_a5_se0", s[24], SE0);
    load_exp(0, s, 1);
    push(0, 8'h00, 0);
    push(0, 8'hA5, 1);
    wait_done(0);

    bytes = {8'h3C};
    load_exp(1, model(bytes), 4);
    oe_cyc[1] = 0;
    push(1, 8'h3C, 1);
    wait_done(1);
    chk("div4_oe_cycles", oe_cyc[1], 76);

    urun_cnt = '{0, 0};
    for (int p = 0; p < 8; p++) begin
      d = (p >= 6) ? 1 : 0;
      len = $urandom_range(1, 10);
      bytes.delete();
      repeat (len) bytes.push_back(8'($urandom));
      load_exp(d, model(bytes), d ? 4 : 1);
      for (int i = 0; i < len; i++) begin
        push(d, bytes[i], i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_done(d);
    end
    chk("rand_no_urun0", urun_cnt[0], 0);
    chk("rand_no_urun1", urun_cnt[1], 0);

    bytes = {8'h11, 8'h22, 8'h33, 8'h44};
    load_exp(0, model(bytes), 1);
    push(0, 8'h11, 0);
    push(0, 8'h22, 0);
    push(0, 8'h33, 0);
    repeat (10) @(negedge clk);
    chk("below_thresh_idle", busy[0], 0);
    push(0, 8'h44, 0);
    n = 0;
    while (!urun[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("urun_seen", urun[0], 1);
    chk("flush_rdy", rdy[0], 1);
    push(0, 8'h55, 0);
    push(0, 8'h66, 0);
    push(0, 8'h77, 1);
    wait_done(0);
    idle_hold(0, "no_restart_urun");
    chk("urun_pulses", urun_cnt[0], 1);

    urun_cnt[0] = 0;
    bytes = {8'h12, 8'h34, 8'h56};
    full = model(bytes);
    s.delete();
    for (int i = 0; i <= 20; i++) s.push_back(full[i]);
    repeat (8) s.push_back(full[20]);
    s.push_back(SE0);
    s.push_back(SE0);
    s.push_back(J);
    load_exp(0, s, 1);
    push(0, 8'h12, 0);
    push(0, 8'h34, 0);
    push(0, 8'h56, 1);
    n = 0;
    while (!oe[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_rdy", rdy[0], 0);
    chk("abort_busy", busy[0], 1);
    wait_done(0);
    idle_hold(0, "abort_fifo_empty");
    chk("abort_no_urun", urun_cnt[0], 0);

    chk_en[0] = 1'b0;
    push(0, 8'h12, 0);
    push(0, 8'h34, 0);
    push(0, 8'h56, 1);
    n = 0;
    while (!oe[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    rst_L = 1'b0;
    @(negedge clk);
    chk("mid_rst_dp", dp[0], 1);
    chk("mid_rst_dm", dm[0], 0);
    chk("mid_rst_oe", oe[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_rdy", rdy[0], 0);
    rst_L = 1'b1;
    idle_hold(0, "rst_fifo_empty");
    chk("rst_rdy_back", rdy[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
